// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared 640x480@60 timing constants, colour type and test-pattern
//            palette for the VGA raster scanner.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    typedef logic [23:0] rgb_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + VGA_H_SYNC - 1;
    localparam int V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + VGA_V_SYNC - 1;

    localparam rgb_t COL_WHITE   = 24'hFFFFFF;
    localparam rgb_t COL_YELLOW  = 24'hFFFF00;
    localparam rgb_t COL_CYAN    = 24'h00FFFF;
    localparam rgb_t COL_GREEN   = 24'h00FF00;
    localparam rgb_t COL_MAGENTA = 24'hFF00FF;
    localparam rgb_t COL_RED     = 24'hFF0000;
    localparam rgb_t COL_BLUE    = 24'h0000FF;
    localparam rgb_t COL_BLACK   = 24'h000000;

    // Classic colour-bar order, left to right.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            3'd5:    c = COL_RED;
            3'd6:    c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_scanner_if
// Brief    : Pixel-enable, frame-ROM address/data and DAC pin bundle of the
//            VGA scanner. master = pixel source / ROM / DAC side.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_scanner_if;
    import vga_pkg::*;

    logic       i_pix_en;
    logic [9:0] o_x;
    logic [8:0] o_y;
    rgb_t       i_rgb;
    logic       o_frame_start;
    rgb_t       o_vga_rgb;
    logic       o_vga_hs;
    logic       o_vga_vs;
    logic       o_vga_blank_n;

    modport master (
        output i_pix_en, i_rgb,
        input  o_x, o_y, o_frame_start, o_vga_rgb, o_vga_hs, o_vga_vs, o_vga_blank_n
    );

    modport slave (
        input  i_pix_en, i_rgb,
        output o_x, o_y, o_frame_start, o_vga_rgb, o_vga_hs, o_vga_vs, o_vga_blank_n
    );

endinterface : vga_scanner_if
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_counter
// Brief    : One raster axis: wrapping position counter with active and sync
//            region decode (active, front porch, sync, back porch order).
// Revision : 1.0 - initial release
// ============================================================================
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    output logic [9:0] count,
    output logic       wrap,
    output logic       active,
    output logic       sync
);

    localparam int         TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam logic [9:0] LAST       = 10'(TOTAL - 1);
    localparam logic [9:0] ACT_END    = 10'(ACTIVE);
    localparam logic [9:0] SYNC_START = 10'(ACTIVE + FP);
    localparam logic [9:0] SYNC_END   = 10'(ACTIVE + FP + SYNC - 1);

    // wrap is a one-cycle strobe so the next axis can chain off it directly.
    assign wrap   = advance && (count == LAST);
    assign active = (count < ACT_END);
    assign sync   = (count >= SYNC_START) && (count <= SYNC_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 10'd0;
        end else if (advance) begin
            count <= wrap ? 10'd0 : count + 10'd1;
        end
    end

endmodule : vga_axis_counter
`default_nettype wire

// File: rtl/vga_scanner.sv
`default_nettype none
// ============================================================================
// Module   : vga_scanner
// Brief    : 640x480@60 raster generator; addresses the frame ROMs and
//            registers returned colour with aligned sync/blank to the DAC.
//            Optional macro VGA_TEST_PATTERN_EN replaces i_rgb with 8 bars.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scanner
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic          i_clk,
    input  logic          i_rst,
    vga_scanner_if.slave  bus
);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       v_wrap_unused;
    logic       h_act;
    logic       v_act;
    logic       h_sync;
    logic       v_sync;
    logic       act;
    rgb_t       pix_rgb;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk     (i_clk),
        .rst     (i_rst),
        .advance (bus.i_pix_en),
        .count   (h_cnt),
        .wrap    (h_wrap),
        .active  (h_act),
        .sync    (h_sync)
    );

    // Vertical axis steps once per line, on the horizontal wrap strobe.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk     (i_clk),
        .rst     (i_rst),
        .advance (h_wrap),
        .count   (v_cnt),
        .wrap    (v_wrap_unused),
        .active  (v_act),
        .sync    (v_sync)
    );

    assign act               = h_act & v_act;
    assign bus.o_x           = h_act ? h_cnt : 10'd0;
    assign bus.o_y           = v_act ? v_cnt[8:0] : 9'd0;
    assign bus.o_frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0) && !i_rst;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
    logic unused_rgb;
    assign unused_rgb = ^bus.i_rgb;
    assign pix_rgb    = bar_colour(3'(h_cnt / BAR_W));
`else
    assign pix_rgb    = bus.i_rgb;
`endif

    // One enabled cycle from counter state to pins, matching the ROM's
    // combinational return so sync/blank stay aligned with colour.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_vga_rgb     <= '0;
            bus.o_vga_hs      <= 1'b1;
            bus.o_vga_vs      <= 1'b1;
            bus.o_vga_blank_n <= 1'b0;
        end else if (bus.i_pix_en) begin
            bus.o_vga_rgb     <= act ? pix_rgb : '0;
            bus.o_vga_hs      <= ~h_sync;
            bus.o_vga_vs      <= ~v_sync;
            bus.o_vga_blank_n <= act;
        end
    end

endmodule : vga_scanner
`default_nettype wire

// File: tb/tb_vga_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vga_scanner
// Brief    : Self-checking bench: full-size scanner for line timing and pixel
//            path, reduced-size scanner for frame-level sync timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scanner;
    import vga_pkg::*;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bn;
    } dac_t;

    typedef struct {
        int          h;
        int          v;
        logic        frc;
        logic [23:0] fval;
        logic [9:0]  ex;
        logic [8:0]  ey;
        logic [23:0] erx;
        logic [23:0] ept;
        logic        ebn;
        logic        ehs;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        rst_s = 1'b1;
    logic        frc   = 1'b0;
    logic [23:0] fval  = 24'h0;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          mh = 0;
    int          mv = 0;
    dac_t        last;
    dac_t        sb[$];

    vga_scanner_if bus();
    vga_scanner_if bus_s();

    always #5 clk = ~clk;

    // Frame ROM model: colour encodes the requested coordinate.
    always_comb bus.i_rgb = frc ? fval : {bus.o_x[7:0], bus.o_y[7:0], 8'hA5};
    assign bus_s.i_rgb = 24'h123456;

    vga_scanner dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    vga_scanner #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (2)
    ) dut_s (
        .i_clk (clk),
        .i_rst (rst_s),
        .bus   (bus_s.slave)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (model h=%0d v=%0d)", name, got, exp, mh, mv);
        end
    endtask

    function automatic logic [23:0] pat(input int h);
        case (h / 80)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic dac_t model_dac();
        dac_t        e;
        logic        a;
        logic [23:0] c;
        a = (mh < 640) && (mv < 480);
`ifdef VGA_TEST_PATTERN_EN
        c = pat(mh);
`else
        c = frc ? fval : {8'(mh), 8'(mv), 8'hA5};
`endif
        e.rgb = a ? c : 24'h0;
        e.hs  = !(mh >= 656 && mh <= 751);
        e.vs  = !(mv >= 490 && mv <= 491);
        e.bn  = a;
        return e;
    endfunction

    function automatic logic [31:0] cur_dac();
        return {5'b0, bus.o_vga_rgb, bus.o_vga_hs, bus.o_vga_vs, bus.o_vga_blank_n};
    endfunction

    task automatic tick(input logic en);
        bus.i_pix_en = en;
        if (en) sb.push_back(model_dac());
        @(posedge clk);
        #1;
        if (en) begin
            if (mh == 799) begin
                mh = 0;
                mv = (mv == 524) ? 0 : mv + 1;
            end else begin
                mh++;
            end
            last = sb.pop_front();
        end
        chk("dac", cur_dac(), {5'b0, last});
        chk("o_x", 32'(bus.o_x), (mh < 640) ? mh : 0);
        chk("o_y", 32'(bus.o_y), (mv < 480) ? mv : 0);
    endtask

    task automatic goto(input int h, input int v);
        int n;
        n = 0;
        while (!(mh == h && mv == v)) begin
            if (n >= 12000) begin
                n_chk++;
                n_fail++;
                $display("FAIL goto_timeout: got h=%0d v=%0d required h=%0d v=%0d", mh, mv, h, v);
                break;
            end
            tick(1'b1);
            n++;
        end
    endtask

    task automatic model_reset();
        mh = 0;
        mv = 0;
        last = '{rgb: 24'h0, hs: 1'b1, vs: 1'b1, bn: 1'b0};
        sb.delete();
    endtask

    initial begin
        vec_t tbl[13];
        dac_t saved;
        int   first_lo, n_lo;
        int   fs1, fs2, hs_first, vs_first, hs_low, vs_low;

        tbl[0]  = '{5,   7,  1'b0, 24'h0,      10'd5,   9'd7,  24'h0507A5, 24'hFFFFFF, 1'b1, 1'b1};
        tbl[1]  = '{700, 7,  1'b1, 24'hFFFFFF, 10'd0,   9'd7,  24'h000000, 24'h000000, 1'b0, 1'b0};
        tbl[2]  = '{0,   8,  1'b0, 24'h0,      10'd0,   9'd8,  24'h0008A5, 24'hFFFFFF, 1'b1, 1'b1};
        tbl[3]  = '{639, 8,  1'b0, 24'h0,      10'd639, 9'd8,  24'h7F08A5, 24'h000000, 1'b1, 1'b1};
        tbl[4]  = '{640, 8,  1'b0, 24'h0,      10'd0,   9'd8,  24'h000000, 24'h000000, 1'b0, 1'b1};
        tbl[5]  = '{655, 8,  1'b0, 24'h0,      10'd0,   9'd8,  24'h000000, 24'h000000, 1'b0, 1'b1};
        tbl[6]  = '{656, 8,  1'b0, 24'h0,      10'd0,   9'd8,  24'h000000, 24'h000000, 1'b0, 1'b0};
        tbl[7]  = '{751, 8,  1'b0, 24'h0,      10'd0,   9'd8,  24'h000000, 24'h000000, 1'b0, 1'b0};
        tbl[8]  = '{752, 8,  1'b0, 24'h0,      10'd0,   9'd8,  24'h000000, 24'h000000, 1'b0, 1'b1};
        tbl[9]  = '{799, 8,  1'b0, 24'h0,      10'd0,   9'd8,  24'h000000, 24'h000000, 1'b0, 1'b1};
        tbl[10] = '{300, 9,  1'b0, 24'h0,      10'd300, 9'd9,  24'h2C09A5, 24'h00FF00, 1'b1, 1'b1};
        tbl[11] = '{85,  10, 1'b0, 24'h0,      10'd85,  9'd10, 24'h550AA5, 24'hFFFF00, 1'b1, 1'b1};
        tbl[12] = '{86,  10, 1'b1, 24'h123456, 10'd86,  9'd10, 24'h123456, 24'hFFFF00, 1'b1, 1'b1};

        bus.i_pix_en   = 1'b0;
        bus_s.i_pix_en = 1'b0;

        // Reset with the pixel enable toggling.
        for (int i = 0; i < 3; i++) begin
            bus.i_pix_en = (i % 2 == 0);
            @(posedge clk);
            #1;
        end
        chk("rst_hs", 32'(bus.o_vga_hs), 1);
        chk("rst_vs", 32'(bus.o_vga_vs), 1);
        chk("rst_blank_n", 32'(bus.o_vga_blank_n), 0);
        chk("rst_rgb", 32'(bus.o_vga_rgb), 0);
        chk("rst_x", 32'(bus.o_x), 0);
        chk("rst_y", 32'(bus.o_y), 0);
        chk("rst_frame_start", 32'(bus.o_frame_start), 0);
        model_reset();
        rst = 1'b0;
        #1;
        chk("frame_start_after_rst", 32'(bus.o_frame_start), 1);

        // First line at half rate: hsync position and width.
        first_lo = -1;
        n_lo = 0;
        for (int i = 1; i <= 800; i++) begin
            tick(1'b0);
            tick(1'b1);
            if (!bus.o_vga_hs) begin
                if (first_lo < 0) first_lo = i;
                n_lo++;
            end
        end
        chk("hs_first_low", first_lo, 657);
        chk("hs_width", n_lo, 96);

        foreach (tbl[i]) begin
            goto(tbl[i].h, tbl[i].v);
            frc  = tbl[i].frc;
            fval = tbl[i].fval;
            #1;
            chk("vec_x", 32'(bus.o_x), 32'(tbl[i].ex));
            chk("vec_y", 32'(bus.o_y), 32'(tbl[i].ey));
            tick(1'b0);
            tick(1'b1);
            frc = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
            chk("vec_rgb", 32'(bus.o_vga_rgb), 32'(tbl[i].ept));
`else
            chk("vec_rgb", 32'(bus.o_vga_rgb), 32'(tbl[i].erx));
`endif
            chk("vec_blank_n", 32'(bus.o_vga_blank_n), 32'(tbl[i].ebn));
            chk("vec_hs", 32'(bus.o_vga_hs), 32'(tbl[i].ehs));
        end

        // Stall at x=300.
        goto(300, 11);
        saved = dac_t'(cur_dac());
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            chk("stall_x", 32'(bus.o_x), 300);
            chk("stall_y", 32'(bus.o_y), 11);
            chk("stall_dac", cur_dac(), {5'b0, saved});
        end
        tick(1'b1);
        chk("resume_x", 32'(bus.o_x), 301);

        // Mid-frame reset, taken while the enable is low.
        goto(300, 12);
        rst = 1'b1;
        bus.i_pix_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mrst_x", 32'(bus.o_x), 0);
        chk("mrst_y", 32'(bus.o_y), 0);
        chk("mrst_frame_start", 32'(bus.o_frame_start), 1);
        chk("mrst_dac", cur_dac(), {5'b0, 24'h0, 1'b1, 1'b1, 1'b0});
        model_reset();
        tick(1'b1);
`ifdef VGA_TEST_PATTERN_EN
        chk("first_pixel", 32'(bus.o_vga_rgb), 32'h00FFFFFF);
`else
        chk("first_pixel", 32'(bus.o_vga_rgb), 32'h000000A5);
`endif
        for (int i = 0; i < 20; i++) tick(1'b1);

        // Reduced geometry: 16 x 9 = 144 enabled cycles per frame, two frames.
        bus_s.i_pix_en = 1'b1;
        @(posedge clk);
        #1;
        rst_s = 1'b0;
        #1;
        chk("s_frame_start0", 32'(bus_s.o_frame_start), 1);
        fs1 = -1; fs2 = -1; hs_first = -1; vs_first = -1; hs_low = 0; vs_low = 0;
        for (int k = 1; k <= 288; k++) begin
            bus_s.i_pix_en = 1'b0;
            @(posedge clk);
            #1;
            bus_s.i_pix_en = 1'b1;
            @(posedge clk);
            #1;
            if (bus_s.o_frame_start) begin
                if (fs1 < 0) fs1 = k;
                else if (fs2 < 0) fs2 = k;
            end
            if (k <= 144) begin
                if (!bus_s.o_vga_hs) begin
                    if (hs_first < 0) hs_first = k;
                    hs_low++;
                end
                if (!bus_s.o_vga_vs) begin
                    if (vs_first < 0) vs_first = k;
                    vs_low++;
                end
            end
        end
        chk("s_frame_start_1", fs1, 144);
        chk("s_frame_start_2", fs2, 288);
        chk("s_hs_first", hs_first, 11);
        chk("s_hs_low_total", hs_low, 27);
        chk("s_vs_first", vs_first, 81);
        chk("s_vs_width", vs_low, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_vga_scanner
`default_nettype wire
